// File: rtl/mult_div_seq.sv
// Sequential 32x32 multiply / divide unit (MIPS HI/LO style).
// Shift-add multiply and restoring divide: one step per cycle, then a sign fix-up cycle.
module mult_div_seq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_a, neg_b;
  logic [31:0] bop;
  logic [63:0] acc;

  // Op[0] set means unsigned; Op[1] set means divide
  logic        a_neg, b_neg, div_zero_req;
  logic [31:0] a_abs, b_abs;

  assign a_neg        = ~Op[0] & A[31];
  assign b_neg        = ~Op[0] & B[31];
  assign a_abs        = a_neg ? -A : A;
  assign b_abs        = b_neg ? -B : B;
  assign div_zero_req = Op[1] && (B == 32'd0);
  assign Busy         = (state != IDLE);

  // Multiply step: low half holds the remaining multiplier bits, high half the running sum.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, bop};
  assign mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

  // Divide step: high half is the remainder, low half shifts dividend out and quotient in.
  logic [32:0] div_part;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_part = {acc[63:32], acc[31]};
  assign div_ge   = (div_part >= {1'b0, bop});
  assign div_sub  = div_part[31:0] - bop;
  assign div_next = div_ge ? {div_sub, acc[30:0], 1'b1}
                           : {div_part[31:0], acc[30:0], 1'b0};

  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div) begin
      fix_lo = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
      fix_hi = neg_a ? -acc[63:32] : acc[63:32];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = div_zero_req ? DONE : RUN;
      RUN:  if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= 5'd0;
      is_div  <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      bop     <= 32'd0;
      acc     <= 64'd0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= (state_nxt == DONE);
      DivZero <= (state == IDLE) && Start && div_zero_req;
      case (state)
        IDLE: if (Start) begin
          cnt    <= 5'd0;
          is_div <= Op[1];
          neg_a  <= a_neg;
          neg_b  <= b_neg;
          bop    <= b_abs;
          acc    <= {32'd0, a_abs};
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          acc <= is_div ? div_next : mul_next;
        end
        FIX: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: arithmetic/latency reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_mult_div_seq;

  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int checks = 0, errors = 0;

  mult_div_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      default: p = {a % b, a / b};
    endcase
    return p;
  endfunction

  // Model: an accepted op stays busy 34 cycles (1 for divide by zero); Done in the last one.
  int          m_cnt = 0;
  logic        m_dz = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] pend = 64'd0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cnt = 0; m_dz = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1 && !m_dz) {m_hi, m_lo} = pend;
      if (m_cnt == 0) m_dz = 1'b0;
    end else if (Start) begin
      if (Op[1] && B == 32'd0) begin
        m_cnt = 1; m_dz = 1'b1;
      end else begin
        m_cnt = 34; m_dz = 1'b0; pend = ref_result(Op, A, B);
      end
    end
  end

  always @(negedge Clk) begin
    chk("busy", {31'd0, Busy}, {31'd0, m_cnt > 0});
    chk("done", {31'd0, Done}, {31'd0, m_cnt == 1});
    chk("divzero", {31'd0, DivZero}, {31'd0, m_cnt == 1 && m_dz});
    chk("hi", Hi, m_hi);
    chk("lo", Lo, m_lo);
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dz, input int exp_lat, input bit noise);
    int n;
    bit seen;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1 Start = 1'b0; A = $urandom; B = $urandom;
    n = 1; seen = 1'b0;
    @(negedge Clk);
    while (n < 60) begin
      if (Done) begin seen = 1'b1; break; end
      @(posedge Clk);
      #1 if (noise) Start = 1'($urandom_range(0, 1));
      n++;
      @(negedge Clk);
    end
    Start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL op_done_timeout: got no Done within %0d edges, required Done", n);
    end else begin
      chk("op_latency", n, exp_lat);
      chk("op_divzero", {31'd0, DivZero}, {31'd0, exp_dz});
      chk("op_hi", Hi, exp_hi);
      chk("op_lo", Lo, exp_lo);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int dn, acc_n, first_i, second_i;
    bit pb;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b0);
    do_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 1'b0);
    do_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 1'b0);
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 1'b1);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    do_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 1'b1);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1'b0);
    do_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, 1'b0);
    do_op(2'b11, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0, 34, 1'b0);
    do_op(2'b10, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 1,  1'b0);
    do_op(2'b11, 32'd9,        32'd0,        32'h11,       32'h22,       1'b1, 1,  1'b0);

    // Reset in the middle of RUN
    Start = 1'b1; Op = 2'b01; A = 32'h1234; B = 32'h5678;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset = 1'b1;
    #1 chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    dn = 0;
    repeat (40) begin @(negedge Clk); if (Done) dn++; end
    chk("midrst_no_done", dn, 32'd0);
    @(posedge Clk);
    #1;
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, 1'b0);

    // Start held high: one accept every 35 cycles
    Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd5;
    dn = 0; acc_n = 0; pb = 1'b0; first_i = -1; second_i = -1;
    for (int i = 0; i < 105; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) dn++;
      if (Busy && !pb) begin
        acc_n++;
        if (first_i < 0) first_i = i; else if (second_i < 0) second_i = i;
      end
      pb = Busy;
    end
    Start = 1'b0;
    chk("held_dones", dn, 32'd3);
    chk("held_accepts", acc_n, 32'd3);
    chk("held_period", second_i - first_i, 32'd35);
    chk("held_lo", Lo, 32'd15);
    repeat (3) @(posedge Clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
